// File: rtl/cycle_extract.sv
// cycle_extract
//   Scans a Bellman-Ford result (vertmat: distance + predecessor, adjmat: edge
//   weights) for an edge that can still be relaxed. On the first such edge it
//   walks the predecessor chain NODES steps so that it is guaranteed to stand
//   inside the negative cycle, then streams that cycle's vertices out over a
//   valid/ready handshake. Memories have a two-cycle read latency, so every
//   probe is address / wait / evaluate with the address held throughout.
//   Optional feature: define CYCLE_EXTRACT_LEN_EN to add the cycle_len output.

`ifndef NODES
`define NODES 4
`endif
`ifndef PRED_WIDTH
`define PRED_WIDTH 1
`endif
`ifndef WEIGHT_WIDTH
`define WEIGHT_WIDTH 30
`endif
`ifndef VERT_WIDTH
`define VERT_WIDTH 32
`endif

module cycle_extract (
  input  logic                   clk,
  input  logic                   cycle_reset_n,
  input  logic                   cycle_start,
  output logic [`PRED_WIDTH:0]   vertmat_addr_a,
  output logic [`PRED_WIDTH:0]   vertmat_addr_b,
  input  logic [`VERT_WIDTH:0]   vertmat_q_a,
  input  logic [`VERT_WIDTH:0]   vertmat_q_b,
  output logic [`PRED_WIDTH:0]   adjmat_row_addr,
  output logic [`PRED_WIDTH:0]   adjmat_col_addr,
  input  logic [`WEIGHT_WIDTH:0] adjmat_q,
  output logic [`PRED_WIDTH:0]   out_vertex,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   cycle_found,
  output logic                   cycle_done
`ifdef CYCLE_EXTRACT_LEN_EN
  ,
  output logic [`PRED_WIDTH+1:0] cycle_len
`endif
);

  localparam int N  = `NODES;
  localparam int IW = `PRED_WIDTH + 1;
  localparam int DW = `WEIGHT_WIDTH + 1;
  localparam int VW = `VERT_WIDTH + 1;
  localparam int LW = `PRED_WIDTH + 2;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [DW-1:0] DIST_INF = DW'(31'h777fffff);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_WALK,
    S_EMIT,
    S_DONE
  } state_t;

  // Probe phases; PH_HOLD is only used in EMIT while a beat is on offer.
  localparam logic [1:0] PH_ADDR = 2'd0;
  localparam logic [1:0] PH_WAIT = 2'd1;
  localparam logic [1:0] PH_EVAL = 2'd2;
  localparam logic [1:0] PH_HOLD = 2'd3;

  state_t          r_state,     w_state_nxt;
  logic [1:0]      r_phase,     w_phase_nxt;
  logic [IW-1:0]   r_i,         w_i_nxt;
  logic [IW-1:0]   r_j,         w_j_nxt;
  logic [IW-1:0]   r_cur,       w_cur_nxt;
  logic [IW-1:0]   r_anchor,    w_anchor_nxt;
  logic [IW-1:0]   r_next,      w_next_nxt;
  logic [IW-1:0]   r_step,      w_step_nxt;
  logic [IW-1:0]   r_emit_cnt,  w_emit_cnt_nxt;
  logic            r_found,     w_found_nxt;
  logic            r_done,      w_done_nxt;
  logic            r_valid,     w_valid_nxt;
  logic            r_last,      w_last_nxt;
`ifdef CYCLE_EXTRACT_LEN_EN
  logic [LW-1:0]   r_len,       w_len_nxt;
`endif

  logic [DW-1:0]    w_dist_a;
  logic [DW-1:0]    w_dist_b;
  logic [IW-1:0]    w_pred_a;
  logic signed [DW:0] w_sum;
  logic             w_hit;
  logic             w_accept;
  logic             w_unused;

  assign w_dist_a = vertmat_q_a[DW-1:0];
  assign w_dist_b = vertmat_q_b[DW-1:0];
  assign w_pred_a = vertmat_q_a[DW +: IW];
  // Port B only ever supplies dist[j]; its predecessor field is not needed.
  assign w_unused = ^vertmat_q_b[VW-1:DW];

  // One extra bit keeps dist[i] + e exact, so the relax test cannot wrap.
  assign w_sum = $signed({w_dist_a[DW-1], w_dist_a}) + $signed({adjmat_q[DW-1], adjmat_q});
  assign w_hit = (adjmat_q != '0) && (w_dist_a != DIST_INF) &&
                 (w_sum < $signed({w_dist_b[DW-1], w_dist_b}));

  assign w_accept = r_valid && out_ready;

  // Memory addresses are a pure function of registered state, so they stay
  // put for the whole address/wait/evaluate sequence of a probe.
  always_comb begin
    vertmat_addr_a  = '0;
    vertmat_addr_b  = '0;
    adjmat_row_addr = '0;
    adjmat_col_addr = '0;
    case (r_state)
      S_SCAN: begin
        vertmat_addr_a  = r_i;
        vertmat_addr_b  = r_j;
        adjmat_row_addr = r_i;
        adjmat_col_addr = r_j;
      end
      S_WALK, S_EMIT: vertmat_addr_a = r_cur;
      default: ;
    endcase
  end

  // Next-state and next-datapath logic for the scan/walk/emit sequencer.
  always_comb begin
    // NOTE: every target gets its hold value first; a path that skips an
    // assignment would otherwise infer a latch.
    w_state_nxt    = r_state;
    w_phase_nxt    = r_phase;
    w_i_nxt        = r_i;
    w_j_nxt        = r_j;
    w_cur_nxt      = r_cur;
    w_anchor_nxt   = r_anchor;
    w_next_nxt     = r_next;
    w_step_nxt     = r_step;
    w_emit_cnt_nxt = r_emit_cnt;
    w_found_nxt    = r_found;
    w_done_nxt     = r_done;
    w_valid_nxt    = r_valid;
    w_last_nxt     = r_last;
`ifdef CYCLE_EXTRACT_LEN_EN
    w_len_nxt      = r_len;
`endif

    case (r_state)
      S_IDLE, S_DONE: begin
        if (cycle_start) begin
          w_state_nxt    = S_SCAN;
          w_phase_nxt    = PH_ADDR;
          w_i_nxt        = '0;
          w_j_nxt        = '0;
          w_step_nxt     = '0;
          w_emit_cnt_nxt = '0;
          w_found_nxt    = 1'b0;
          w_done_nxt     = 1'b0;
`ifdef CYCLE_EXTRACT_LEN_EN
          w_len_nxt      = '0;
`endif
        end
      end

      S_SCAN: begin
        if (r_phase != PH_EVAL) begin
          w_phase_nxt = r_phase + 2'd1;
        end else begin
          w_phase_nxt = PH_ADDR;
          if (w_hit) begin
            w_cur_nxt   = r_j;
            w_found_nxt = 1'b1;
            w_step_nxt  = '0;
            w_state_nxt = S_WALK;
          end else if (r_j == LAST_IDX) begin
            w_j_nxt = '0;
            if (r_i == LAST_IDX) begin
              w_state_nxt = S_DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_i_nxt = r_i + IW'(1);
            end
          end else begin
            w_j_nxt = r_j + IW'(1);
          end
        end
      end

      // NODES predecessor hops from any vertex always land on a cycle. A
      // chain passing through the source vertex is not special-cased.
      S_WALK: begin
        if (r_phase != PH_EVAL) begin
          w_phase_nxt = r_phase + 2'd1;
        end else begin
          w_phase_nxt = PH_ADDR;
          w_cur_nxt   = w_pred_a;
          w_step_nxt  = r_step + IW'(1);
          if (r_step == LAST_IDX) begin
            w_anchor_nxt   = w_pred_a;
            w_emit_cnt_nxt = '0;
            w_state_nxt    = S_EMIT;
          end
        end
      end

      // The beat is registered once pred[cur] lands and then frozen until
      // accepted, so out_* never depend on out_ready combinationally.
      S_EMIT: begin
        case (r_phase)
          PH_ADDR, PH_WAIT: w_phase_nxt = r_phase + 2'd1;
          PH_EVAL: begin
            w_phase_nxt = PH_HOLD;
            w_valid_nxt = 1'b1;
            w_next_nxt  = w_pred_a;
            w_last_nxt  = (w_pred_a == r_anchor) || (r_emit_cnt == LAST_IDX);
          end
          default: begin
            if (w_accept) begin
              w_valid_nxt = 1'b0;
              w_last_nxt  = 1'b0;
              w_cur_nxt   = r_next;
`ifdef CYCLE_EXTRACT_LEN_EN
              w_len_nxt   = r_len + LW'(1);
`endif
              if (r_last) begin
                w_state_nxt = S_DONE;
                w_done_nxt  = 1'b1;
              end else begin
                w_emit_cnt_nxt = r_emit_cnt + IW'(1);
                w_phase_nxt    = PH_ADDR;
              end
            end
          end
        endcase
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any beat on offer at once.
  always_ff @(posedge clk or negedge cycle_reset_n) begin
    if (!cycle_reset_n) begin
      r_state    <= S_IDLE;
      r_phase    <= PH_ADDR;
      r_i        <= '0;
      r_j        <= '0;
      r_cur      <= '0;
      r_anchor   <= '0;
      r_next     <= '0;
      r_step     <= '0;
      r_emit_cnt <= '0;
      r_found    <= 1'b0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
`ifdef CYCLE_EXTRACT_LEN_EN
      r_len      <= '0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_i        <= w_i_nxt;
      r_j        <= w_j_nxt;
      r_cur      <= w_cur_nxt;
      r_anchor   <= w_anchor_nxt;
      r_next     <= w_next_nxt;
      r_step     <= w_step_nxt;
      r_emit_cnt <= w_emit_cnt_nxt;
      r_found    <= w_found_nxt;
      r_done     <= w_done_nxt;
      r_valid    <= w_valid_nxt;
      r_last     <= w_last_nxt;
`ifdef CYCLE_EXTRACT_LEN_EN
      r_len      <= w_len_nxt;
`endif
    end
  end

  assign out_vertex  = r_cur;
  assign out_valid   = r_valid;
  assign out_last    = r_last;
  assign cycle_found = r_found;
  assign cycle_done  = r_done;
`ifdef CYCLE_EXTRACT_LEN_EN
  assign cycle_len   = r_len;
`endif

endmodule

// File: tb/tb_cycle_extract.sv
// tb_cycle_extract: drives cycle_extract from a two-cycle-latency memory model
// and compares every offered beat against a graph-level reference model.

`timescale 1ns/1ps

`ifndef NODES
`define NODES 4
`endif
`ifndef PRED_WIDTH
`define PRED_WIDTH 1
`endif
`ifndef WEIGHT_WIDTH
`define WEIGHT_WIDTH 30
`endif
`ifndef VERT_WIDTH
`define VERT_WIDTH 32
`endif

module tb_cycle_extract;

  localparam int N  = `NODES;
  localparam int IW = `PRED_WIDTH + 1;
  localparam int DW = `WEIGHT_WIDTH + 1;
  localparam int VW = `VERT_WIDTH + 1;
  localparam logic [DW-1:0] INF = DW'(31'h777fffff);

  logic          clk = 1'b0;
  logic          cycle_reset_n;
  logic          cycle_start;
  logic [IW-1:0] vertmat_addr_a, vertmat_addr_b;
  logic [VW-1:0] vertmat_q_a, vertmat_q_b;
  logic [IW-1:0] adjmat_row_addr, adjmat_col_addr;
  logic [DW-1:0] adjmat_q;
  logic [IW-1:0] out_vertex;
  logic          out_valid, out_ready, out_last;
  logic          cycle_found, cycle_done;
`ifdef CYCLE_EXTRACT_LEN_EN
  logic [IW:0]   cycle_len;
`endif

  always #5 clk = ~clk;

  cycle_extract dut (
    .clk             (clk),
    .cycle_reset_n   (cycle_reset_n),
    .cycle_start     (cycle_start),
    .vertmat_addr_a  (vertmat_addr_a),
    .vertmat_addr_b  (vertmat_addr_b),
    .vertmat_q_a     (vertmat_q_a),
    .vertmat_q_b     (vertmat_q_b),
    .adjmat_row_addr (adjmat_row_addr),
    .adjmat_col_addr (adjmat_col_addr),
    .adjmat_q        (adjmat_q),
    .out_vertex      (out_vertex),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_last        (out_last),
    .cycle_found     (cycle_found),
    .cycle_done      (cycle_done)
`ifdef CYCLE_EXTRACT_LEN_EN
    ,
    .cycle_len       (cycle_len)
`endif
  );

  // Graph contents and the two-stage read pipeline of the memories.
  logic [DW-1:0] m_dist [N];
  logic [IW-1:0] m_pred [N];
  logic [DW-1:0] m_adj  [N][N];
  logic [VW-1:0] qa_d1, qb_d1;
  logic [DW-1:0] qe_d1;

  always @(posedge clk) begin
    qa_d1       <= {m_pred[vertmat_addr_a], m_dist[vertmat_addr_a]};
    qb_d1       <= {m_pred[vertmat_addr_b], m_dist[vertmat_addr_b]};
    qe_d1       <= m_adj[adjmat_row_addr][adjmat_col_addr];
    vertmat_q_a <= qa_d1;
    vertmat_q_b <= qb_d1;
    adjmat_q    <= qe_d1;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_total++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Reference model: first relaxable edge in row-major order, NODES pred
  // hops, then the pred chain from the anchor until it closes.
  int exp_beats[$];
  bit exp_found;
  int exp_len;

  function automatic longint sval(input logic [DW-1:0] x);
    return x[DW-1] ? longint'(x) - (longint'(1) << DW) : longint'(x);
  endfunction

  task automatic compute_model();
    int cur, anchor, v, cnt;
    exp_beats.delete();
    exp_found = 0;
    cur = 0;
    for (int i = 0; i < N && !exp_found; i++) begin
      for (int j = 0; j < N && !exp_found; j++) begin
        if (m_adj[i][j] != 0 && m_dist[i] != INF &&
            sval(m_dist[i]) + sval(m_adj[i][j]) < sval(m_dist[j])) begin
          exp_found = 1;
          cur = j;
        end
      end
    end
    if (exp_found) begin
      for (int k = 0; k < N; k++) cur = int'(m_pred[cur]);
      anchor = cur;
      v = anchor;
      cnt = 0;
      forever begin
        exp_beats.push_back(v);
        cnt++;
        if (int'(m_pred[v]) == anchor || cnt == N) break;
        v = int'(m_pred[v]);
      end
    end
    exp_len = exp_beats.size();
  endtask

  // Compare process: every cycle a beat is on offer it must match the head
  // of the expected queue, and a stalled beat must not change.
  int   beats_seen;
  logic prev_stall = 1'b0;
  logic [IW-1:0] prev_vertex;
  logic prev_last;

  always @(negedge clk) begin
    if (!cycle_reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_vertex", out_vertex, prev_vertex);
        check("hold_last", out_last, prev_last);
      end
      if (out_valid) begin
        if (exp_beats.size() == 0) begin
          check("unexpected_valid", out_valid, 0);
        end else begin
          check("beat_vertex", out_vertex, exp_beats[0]);
          check("beat_last", out_last, exp_beats.size() == 1);
          if (out_ready) begin
            void'(exp_beats.pop_front());
            beats_seen++;
          end
        end
      end
      prev_stall  = out_valid && !out_ready;
      prev_vertex = out_vertex;
      prev_last   = out_last;
    end
  end

  // Ready driver: 0 always ready, 1 random, 2 stall 5 cycles on beat 2,
  // 3 never ready.
  int ready_mode = 0;
  int stall_cnt  = 0;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (beats_seen == 1 && out_valid && stall_cnt < 5) begin
            out_ready = 1'b0;
            stall_cnt++;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic clear_mem();
    for (int v = 0; v < N; v++) begin
      m_dist[v] = '0;
      m_pred[v] = '0;
      for (int w = 0; w < N; w++) m_adj[v][w] = '0;
    end
  endtask

  task automatic setup_ring();
    clear_mem();
    m_adj[1][2] = DW'(-1);
    m_adj[2][3] = DW'(-1);
    m_adj[3][1] = DW'(-1);
    m_pred[2] = IW'(1);
    m_pred[3] = IW'(2);
    m_pred[1] = IW'(3);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 cycle_start = 1'b1;
    @(posedge clk);
    #1 cycle_start = 1'b0;
  endtask

  // One full extraction; an extra start is thrown in while a beat is offered
  // when 'extra' is set, and it must be ignored.
  task automatic run_case(input int mode, input bit extra, output int cycles);
    bit pulsed;
    compute_model();
    ready_mode = mode;
    stall_cnt  = 0;
    beats_seen = 0;
    pulsed     = 0;
    pulse_start();
    cycles = 0;
    while (!cycle_done && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      cycle_start = 1'b0;
      if (extra && out_valid && !pulsed) begin
        cycle_start = 1'b1;
        pulsed = 1;
      end
    end
    cycle_start = 1'b0;
    check("done_reached", cycle_done, 1);
    check("found", cycle_found, exp_found);
    check("beats_left", exp_beats.size(), 0);
    check("beats_count", beats_seen, exp_len);
`ifdef CYCLE_EXTRACT_LEN_EN
    check("cycle_len", cycle_len, exp_len);
`endif
  endtask

  initial begin
    int cyc;
    int cnt;
    cycle_reset_n = 1'b0;
    cycle_start   = 1'b0;
    beats_seen    = 0;
    clear_mem();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_found", cycle_found, 0);
    check("rst_done", cycle_done, 0);
    check("rst_vertex", out_vertex, 0);
    check("rst_addr_a", vertmat_addr_a, 0);
    check("rst_addr_row", adjmat_row_addr, 0);
    @(posedge clk);
    #2 cycle_reset_n = 1'b1;

    // Consistent shortest-path distances: no relaxable edge anywhere.
    clear_mem();
    m_dist[1] = DW'(2);  m_dist[2] = DW'(5);  m_dist[3] = DW'(7);
    m_adj[0][1] = DW'(2); m_adj[1][2] = DW'(3); m_adj[2][3] = DW'(2);
    m_pred[1] = IW'(0);  m_pred[2] = IW'(1);  m_pred[3] = IW'(2);
    compute_model();
    check("model_nocycle_found", exp_found, 0);
    run_case(0, 0, cyc);
    // 16 probes x 3 cycles after the start edge, seen on the next negedge.
    check("nocycle_latency", cyc, 49);

    // Three-vertex negative ring 1->2->3->1.
    setup_ring();
    compute_model();
    check("model_ring_found", exp_found, 1);
    check("model_ring_beats",
          exp_beats.size() == 3 ? exp_beats[0] * 100 + exp_beats[1] * 10 + exp_beats[2] : -1, 132);
    run_case(0, 0, cyc);

    // Same ring, beat 2 stalled for 5 cycles, stray start during emission.
    setup_ring();
    run_case(2, 1, cyc);
    check("stall_cycles", stall_cnt, 5);

    // Infinite source distance suppresses the -5 edge out of vertex 0.
    clear_mem();
    m_dist[0] = INF;
    m_adj[0][1] = DW'(-5);
    compute_model();
    check("model_inf_found", exp_found, 0);
    run_case(1, 0, cyc);

    // Asynchronous reset while a beat is on offer.
    setup_ring();
    compute_model();
    ready_mode = 3;
    beats_seen = 0;
    pulse_start();
    cnt = 0;
    while (!out_valid && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    check("rst_reach_emit", out_valid, 1);
    @(posedge clk);
    #2 cycle_reset_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_found", cycle_found, 0);
    check("async_rst_done", cycle_done, 0);
    exp_beats.delete();
    ready_mode = 0;
    #10;
    @(posedge clk);
    #2 cycle_reset_n = 1'b1;
    setup_ring();
    run_case(0, 0, cyc);

    // Random graphs, including extreme distances and weights.
    for (int t = 0; t < 40; t++) begin
      for (int v = 0; v < N; v++) begin
        case ($urandom_range(0, 9))
          0:       m_dist[v] = INF;
          1:       m_dist[v] = DW'(31'h3fff_fff0);
          2:       m_dist[v] = DW'(31'h4000_0005);
          default: m_dist[v] = DW'(int'($urandom_range(0, 16)) - 8);
        endcase
        m_pred[v] = IW'($urandom_range(0, N - 1));
        for (int w = 0; w < N; w++) begin
          case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: m_adj[v][w] = '0;
            5:             m_adj[v][w] = DW'(31'h3fff_ffff);
            6:             m_adj[v][w] = DW'(31'h4000_0000);
            default:       m_adj[v][w] = $urandom_range(0, 1) ? DW'(int'($urandom_range(1, 6)))
                                                              : DW'(-int'($urandom_range(1, 6)));
          endcase
        end
      end
      run_case(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cycle_extract.md
CYCLE_EXTRACT -- requirements
Module: cycle_extract

Interface
REQ-001 clk  in  1  single clock; all flops rise-edge.
REQ-002 cycle_reset_n  in  1  asynchronous active-low reset.
REQ-003 cycle_start  in  1  one-cycle pulse that starts extraction; issued after bellman_done.
REQ-004 vertmat_addr_a, vertmat_addr_b  out  `PRED_WIDTH+1  read addresses for vertmat ports A and B (read-only use, no write enables).
REQ-005 vertmat_q_a, vertmat_q_b  in  `VERT_WIDTH+1  vertmat read data; bits [`WEIGHT_WIDTH:0] are signed distance, the `PRED_WIDTH+1 bits directly above are predecessor.
REQ-006 adjmat_row_addr, adjmat_col_addr  out  `PRED_WIDTH+1  edge-weight read address (row = source i, column = destination j).
REQ-007 adjmat_q  in  `WEIGHT_WIDTH+1  signed edge weight; 0 = no edge.
REQ-008 out_vertex  out  `PRED_WIDTH+1  cycle vertex index.
REQ-009 out_valid  out  1 / out_ready  in  1 / out_last  out  1  vertex stream handshake; out_last marks final vertex.
REQ-010 cycle_found  out  1  a negative cycle was detected.
REQ-011 cycle_done  out  1  extraction finished; held until next accepted cycle_start.

Function
REQ-012 States: IDLE, SCAN, WALK, EMIT, DONE; transitions occur only as stated in REQ-013 to REQ-020.
REQ-013 Memory read latency is 2 cycles: each probe is address cycle, wait cycle, evaluate cycle (3 cycles/probe); addresses are held stable across all three cycles.
REQ-014 IDLE/DONE + cycle_start -> SCAN with i=0, j=0, cycle_found=0, cycle_done=0; cycle_start in SCAN/WALK/EMIT is ignored.
REQ-015 SCAN: port A addr=i, port B addr=j, adjmat (i,j); hit when e!=0, dist[i]!=31'h777fffff (infinite), and signed(dist[i]+e) < signed(dist[j]); sum is computed at `WEIGHT_WIDTH+2 bits to avoid overflow.
REQ-016 SCAN order: j increments fastest, then i; after pair (`NODES-1,`NODES-1) with no hit -> DONE, cycle_found=0.
REQ-017 On a hit: cur <= j, cycle_found <= 1, step counter cleared, -> WALK.
REQ-018 WALK: read pred[cur] on port A, cur <= pred; exactly `NODES steps, then anchor <= cur, -> EMIT.
REQ-019 EMIT: out_vertex=cur and out_valid=1 once the read of pred[cur] has landed; on out_valid & out_ready, cur <= pred[cur]. out_last=1 when pred[cur]==anchor, or when this is the `NODES-th emitted vertex (guard).
REQ-020 Emission order is anchor, pred(anchor), pred(pred(anchor)), ...; anchor is emitted exactly once.
REQ-021 out_vertex, out_last and out_valid are stable while out_valid & !out_ready; out_valid never depends combinationally on out_ready.
REQ-022 Last handshake -> DONE; cycle_done asserts the next cycle.
REQ-023 src is used only in WALK: if pred chain reaches src with dist[src]==0 before `NODES steps, the walk continues unchanged (no early exit).

Reset
REQ-024 Reset asserted at any time, including mid-SCAN, mid-WALK, or mid-EMIT with out_valid high, forces IDLE immediately; any pending stream beat is dropped.
REQ-025 Reset values: all addresses 0, out_vertex 0, out_valid 0, out_last 0, cycle_found 0, cycle_done 0, i/j/cur/anchor/counters 0.

Configuration
REQ-026 Macro CYCLE_EXTRACT_LEN_EN: when defined, adds output cycle_len (`PRED_WIDTH+2 bits), reset 0 and cleared on start, incremented per accepted vertex, valid when cycle_done=1.
REQ-027 Without CYCLE_EXTRACT_LEN_EN, cycle_len port and counter are absent; all other behaviour is identical.

Verification (`NODES=4)
REQ-028 No negative cycle: consistent distances, start -> cycle_done after 16 probes (about 48 cycles), cycle_found=0, out_valid never high.
REQ-029 Edges 1->2 (-1), 2->3 (-1), 3->1 (-1), preds 2:1, 3:2, 1:3 -> cycle_found=1, exactly 3 beats, anchor first then its pred chain, out_last on 3rd beat.
REQ-030 Same as REQ-029 with out_ready low for 5 cycles at beat 2 -> out_vertex/out_last held constant, no beat lost or repeated.
REQ-031 Vertex 0 at 31'h777fffff with -5 edge 0->1 -> no hit from row 0, cycle_found=0.
REQ-032 Reset pulse mid-EMIT with out_valid=1 -> out_valid=0, cycle_found=0, cycle_done=0 asynchronously; a new cycle_start reproduces the REQ-029 result.
REQ-033 With CYCLE_EXTRACT_LEN_EN, REQ-029 stimulus -> cycle_len=3 at cycle_done.
